// File: rtl/floppy_uart_tx.sv
// Buffered 8N1 UART transmitter: a small circular FIFO in front of a
// start/data/stop serialiser that drives a registered, idle-high line.
module floppy_uart_tx #(
    parameter int CLK_HZ = 24000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overrun,
    output logic       txd
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [TW-1:0] RELOAD  = TW'(DIV - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          pop_d, pop_q;
    logic          txd_q;
    logic          ovr_q;
    logic          push;

    assign full    = (cnt_q == DEPTH_C);
    assign empty   = (cnt_q == '0);
    assign busy    = (state_q != IDLE);
    assign overrun = ovr_q;
    assign txd     = txd_q;
    assign push    = wr && !full;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        pop_d    = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_d = RELOAD;
                if (!empty) begin
                    shreg_d  = mem_q[rptr_q];
                    bitcnt_d = '0;
                    pop_d    = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (tmr_q == '0) begin
                    tmr_d   = RELOAD;
                    state_d = DATA;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            DATA: begin
                if (tmr_q == '0) begin
                    tmr_d   = RELOAD;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            STOP: begin
                if (tmr_q == '0) begin
                    tmr_d = RELOAD;
                    if (!empty) begin
                        shreg_d  = mem_q[rptr_q];
                        bitcnt_d = '0;
                        pop_d    = 1'b1;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wptr_q] <= data;
        end
    end

    // The head byte is copied into shreg on the pop edge; the pointer and
    // count retire one clock later, which is when empty/full reflect it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tmr_q    <= RELOAD;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            pop_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            txd_q    <= 1'b1;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            pop_q    <= pop_d;
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_q) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({push, pop_q})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (wr && full) begin
                ovr_q <= 1'b1;
            end
            case (state_q)
                START:   txd_q <= 1'b0;
                DATA:    txd_q <= shreg_q[0];
                default: txd_q <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_floppy_uart_tx.sv
// Self-checking bench for floppy_uart_tx at DIV=10, DEPTH=4: fixed frame
// vectors, hand-built FIFO corner sequences and a randomized timing model.
module tb_floppy_uart_tx;

    logic       clk = 1'b0;
    logic       reset, wr;
    logic [7:0] data;
    logic       full, empty, busy, overrun, txd;

    floppy_uart_tx #(.CLK_HZ(1000), .BAUD(100), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .wr(wr), .data(data),
        .full(full), .empty(empty), .busy(busy), .overrun(overrun), .txd(txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line monitors: falling-edge and busy-cycle totals, plus a mid-bit UART receiver.
    int   falls = 0;
    int   busy_total = 0;
    logic txd_prev = 1'b1;
    always @(negedge clk) begin
        if (txd_prev === 1'b1 && txd === 1'b0) falls <= falls + 1;
        if (busy === 1'b1) busy_total <= busy_total + 1;
        txd_prev <= txd;
    end

    typedef struct {
        logic [9:0] bits;
        int         t;
    } frame_t;
    frame_t rxq[$];
    frame_t rf;

    initial begin : receiver
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                rf.t = cyc;
                repeat (5) @(negedge clk);
                rf.bits[0] = txd;
                for (int k = 1; k < 10; k++) begin
                    repeat (10) @(negedge clk);
                    rf.bits[k] = txd;
                end
                rxq.push_back(rf);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic write(input logic [7:0] d);
        wr   = 1'b1;
        data = d;
        tick();
        wr   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(busy === 1'b0 && empty === 1'b1) && n < 3000) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(n < 3000), 1);
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (rxq.size() < n && k < 3000) begin
            tick();
            k++;
        end
        check("frames_arrived", rxq.size(), n);
    endtask

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;
    } vec_t;
    vec_t vecs[5];

    int         a0, b0, f0, t, cnt, pops, fexp, last_f;
    logic       ovr_m;
    int         fall_m[$];
    logic [7:0] exp_b[$];
    logic [7:0] rb;

    initial begin
        // Frame vectors: bit 0 = start, bits 8:1 = data LSB first, bit 9 = stop.
        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};

        reset = 1'b1;
        wr    = 1'b0;
        data  = '0;
        repeat (2) tick();
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            wait_idle();
            rxq.delete();
            b0 = busy_total;
            write(vecs[i].d);
            a0 = cyc;
            check($sformatf("v%0d_empty_after_wr", i), empty, 0);
            check($sformatf("v%0d_busy_e0", i), busy, 0);
            tick();
            check($sformatf("v%0d_busy_e1", i), busy, 1);
            check($sformatf("v%0d_txd_e1", i), txd, 1);
            tick();
            check($sformatf("v%0d_txd_e2", i), txd, 0);
            check($sformatf("v%0d_empty_e2", i), empty, 1);
            wait_frames(1);
            if (rxq.size() > 0) begin
                check($sformatf("v%0d_frame", i), rxq[0].bits, vecs[i].frame);
                check($sformatf("v%0d_latency", i), rxq[0].t - a0, 2);
            end
            wait_idle();
            check($sformatf("v%0d_busy_len", i), busy_total - b0, 100);
        end

        // Back-to-back frames from consecutive writes.
        wait_idle();
        rxq.delete();
        write(8'h00);
        write(8'hFF);
        write(8'h55);
        wait_frames(3);
        if (rxq.size() == 3) begin
            check("b2b_byte0", rxq[0].bits[8:1], 8'h00);
            check("b2b_byte1", rxq[1].bits[8:1], 8'hFF);
            check("b2b_byte2", rxq[2].bits[8:1], 8'h55);
            check("b2b_stop2", rxq[2].bits[9], 1);
            check("b2b_gap01", rxq[1].t - rxq[0].t, 100);
            check("b2b_gap12", rxq[2].t - rxq[1].t, 100);
        end

        // Six writes into a four-deep FIFO: sixth is dropped.
        do_reset();
        rxq.delete();
        for (int i = 1; i <= 5; i++) write(8'(i));
        check("ovf_full", full, 1);
        check("ovf_overrun_pre", overrun, 0);
        write(8'h06);
        check("ovf_overrun", overrun, 1);
        check("ovf_full_after", full, 1);
        wait_frames(5);
        for (int i = 0; i < rxq.size() && i < 5; i++)
            check($sformatf("ovf_byte%0d", i), rxq[i].bits[8:1], 8'(i + 1));
        repeat (200) tick();
        check("ovf_no_extra", rxq.size(), 5);
        check("ovf_overrun_sticky", overrun, 1);

        // Write on the STOP last clock while full: dropped, count 4 -> 3.
        do_reset();
        rxq.delete();
        check("sim4_overrun_cleared", overrun, 0);
        write(8'h11);
        a0 = cyc;
        for (int i = 2; i <= 5; i++) write(8'h10 + 8'(i));
        while (cyc < a0 + 100) tick();
        check("sim4_full_pre", full, 1);
        write(8'h99);
        check("sim4_overrun", overrun, 1);
        tick();
        check("sim4_full_post", full, 0);
        check("sim4_empty_post", empty, 0);
        wait_frames(5);
        for (int i = 0; i < rxq.size() && i < 5; i++)
            check($sformatf("sim4_byte%0d", i), rxq[i].bits[8:1], 8'h11 + 8'(i));
        if (rxq.size() >= 2) check("sim4_gap", rxq[1].t - rxq[0].t, 100);

        // Same with two queued: accepted, delivered in order.
        do_reset();
        rxq.delete();
        write(8'h21);
        a0 = cyc;
        write(8'h22);
        write(8'h23);
        while (cyc < a0 + 100) tick();
        write(8'h77);
        check("sim2_overrun", overrun, 0);
        tick();
        check("sim2_full", full, 0);
        check("sim2_empty", empty, 0);
        wait_frames(4);
        if (rxq.size() == 4) begin
            check("sim2_b0", rxq[0].bits[8:1], 8'h21);
            check("sim2_b1", rxq[1].bits[8:1], 8'h22);
            check("sim2_b2", rxq[2].bits[8:1], 8'h23);
            check("sim2_b3", rxq[3].bits[8:1], 8'h77);
            check("sim2_gap3", rxq[3].t - rxq[2].t, 100);
        end

        // Reset during data bit 3 with two bytes queued; wr alongside is ignored.
        do_reset();
        rxq.delete();
        write(8'h31);
        a0 = cyc;
        write(8'h32);
        write(8'h33);
        while (cyc < a0 + 44) tick();
        reset = 1'b1;
        wr    = 1'b1;
        data  = 8'hEE;
        tick();
        reset = 1'b0;
        wr    = 1'b0;
        check("mrst_txd", txd, 1);
        check("mrst_busy", busy, 0);
        check("mrst_empty", empty, 1);
        check("mrst_full", full, 0);
        check("mrst_overrun", overrun, 0);
        f0 = falls;
        tick();
        check("mrst_wr_ignored", empty, 1);
        repeat (300) tick();
        check("mrst_no_start", falls - f0, 0);
        rxq.delete();
        write(8'h44);
        wait_frames(1);
        if (rxq.size() == 1) check("mrst_new_byte", rxq[0].bits[8:1], 8'h44);

        // Randomized traffic against a timing model: byte k goes on the line at
        // max(accept+2, previous start+100); it leaves the FIFO at that same edge.
        wait_idle();
        do_reset();
        rxq.delete();
        fall_m.delete();
        exp_b.delete();
        last_f = -1000;
        ovr_m  = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            t    = cyc;
            pops = 0;
            foreach (fall_m[j]) if (fall_m[j] <= t) pops++;
            cnt = fall_m.size() - pops;
            check("rnd_full", full, 32'(cnt == 4));
            check("rnd_empty", empty, 32'(cnt == 0));
            check("rnd_overrun", overrun, 32'(ovr_m));
            wr = ($urandom_range(0, 99) < ((n < 2000) ? 1 : 8)) && (n < 3800);
            rb = 8'($urandom);
            data = rb;
            if (wr) begin
                if (cnt < 4) begin
                    fexp = (t + 3 > last_f + 100) ? t + 3 : last_f + 100;
                    fall_m.push_back(fexp);
                    exp_b.push_back(rb);
                    last_f = fexp;
                end else begin
                    ovr_m = 1'b1;
                end
            end
            tick();
        end
        wr = 1'b0;
        wait_frames(exp_b.size());
        for (int i = 0; i < rxq.size() && i < exp_b.size(); i++) begin
            check($sformatf("rnd_byte%0d", i), rxq[i].bits[8:1], exp_b[i]);
            check($sformatf("rnd_framing%0d", i), {rxq[i].bits[9], rxq[i].bits[0]}, 2'b10);
            check($sformatf("rnd_start_t%0d", i), rxq[i].t, fall_m[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/floppy_uart_tx.md
# floppy_uart_tx

Buffered 8N1 UART transmitter that consumes the floppy controller's debug byte stream and drives the board `UART_TXD` pin. It sits directly downstream of the floppy subsystem's debug output in the floppy workbench top, alongside the SD card and seven-segment display outputs. It decouples the bursty CPU-side writes from the slow serial line with a small FIFO. It reports full/empty/overrun status back to the writer.

## Interface
Parameters:
- `CLK_HZ`, 24000000, frequency of `clk` in Hz.
- `BAUD`, 115200, line rate in baud.
- `DEPTH`, 16, FIFO depth in bytes. Must be a power of two, at least 2.
- Derived: `DIV = (CLK_HZ + BAUD/2) / BAUD` clocks per bit, integer division. This is 208 at the defaults. `DIV >= 2` is required.

Ports:
- `clk`  in  1  system clock (`clk24` domain). Single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr`  in  1  write strobe. One byte is offered per cycle in which it is high.
- `data`  in  8  byte to enqueue, sampled when `wr` is high.
- `full`  out  1  FIFO holds `DEPTH` bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `busy`  out  1  a frame is on the line (any state other than IDLE).
- `overrun`  out  1  sticky. Set when a write is dropped.
- `txd`  out  1  serial output, idle high. Registered.

## Operation
FIFO:
- Circular buffer of `DEPTH` entries.
- Read and write pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`.
- Occupancy counter is `log2(DEPTH)+1` bits.
- `full` and `empty` are decoded from the registered count; no combinational path from `wr`.
- A write is accepted when `wr && !full`, where `full` is the pre-edge value.
- A write with `full=1` is dropped and sets `overrun`, even if a pop occurs on the same edge.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.

Transmitter FSM, states IDLE, START, DATA, STOP:
- **IDLE**: `txd=1`. If `!empty`: pop the head byte into the 8-bit shift register, clear the bit counter, go to START.
- **START**: `txd=0` for `DIV` clocks, then go to DATA.
- **DATA**: `txd = shreg[0]` for `DIV` clocks per bit, then shift right. LSB is sent first. After the 8th bit, go to STOP.
- **STOP**: `txd=1` for `DIV` clocks. On its last clock:
  - if `!empty`, pop the next byte and go straight to START (no idle gap);
  - otherwise go to IDLE.
- Bit timer: down-counter of `ceil(log2(DIV))` bits, reloaded with `DIV-1` on every state or bit transition. The bit ends when it reaches 0.

Reset (values on the clock after `reset` is sampled high, including mid-frame):
- `txd=1`, `busy=0`, `empty=1`, `full=0`, `overrun=0`.
- Pointers and count cleared; FSM in IDLE. Bytes in flight and queued are discarded.
- A `wr` in the same cycle as `reset` is ignored.

## Timing
- Write-to-line latency:
  - With FIFO empty and FSM in IDLE, a write accepted at edge E0 causes the IDLE pop at E1.
  - `txd` falls at edge E2, so the start bit begins two clocks after the accepting edge.
  - `empty` rises again at E2.
- `busy` rises with the START transition and falls on the edge entering IDLE.
- Frame length is exactly `10*DIV` clocks: start, 8 data bits, stop.
- Back-to-back frames have period exactly `10*DIV` with no extra cycle between stop and start.
- `full` and `empty` update on the edge following the write or pop that changes the count.
- `overrun` sets on the edge that drops the write. It is cleared only by `reset`.
- Sustained throughput is 1 byte per `10*DIV` clocks. The writer must throttle on `full`.

## Test plan
Bench parameters: `CLK_HZ=1000`, `BAUD=100` (`DIV=10`), `DEPTH=4`.
- **Single byte**: reset, then `wr` with `data=0xA5` for one cycle. Required: `txd` falls 2 clocks later. Bits sampled mid-bit are 0, 1,0,1,0,0,1,0,1, then 1 (start, LSB-first data, stop). `busy` is high for exactly 100 clocks. `empty` returns to 1.
- **Back-to-back**: write 0x00, 0xFF, 0x55 on consecutive cycles. Required: three frames with start-bit falling edges exactly 100 clocks apart, decoded 0x00, 0xFF, 0x55, no idle gap.
- **Full/overrun**: write 6 bytes 0x01–0x06 on consecutive cycles. Required:
  - 0x01 is popped; 0x02–0x05 fill the FIFO, so `full=1`;
  - 0x06 is dropped and `overrun=1`;
  - the line carries 0x01–0x05 only.
- **Simultaneous write and pop**: with `full=1`, assert `wr` on the STOP last clock. Required: the write is dropped, `overrun` sets, and count goes from 4 to 3. Repeat with count=2: count stays 2 and the byte is delivered in order.
- **Reset mid-frame**: assert `reset` during DATA bit 3 with 2 bytes queued. Required: `txd=1` next clock, `busy=0`, `empty=1`, `overrun=0`. No further start bit until a new `wr`.
